// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path.
// Contents: controller state encoding, opcode/funct codes, the aluOp
// encodings understood by the existing ALU, and the aluSrcB/pcSrc mux
// encodings. It also defines the ALU-class encoding that the FSM hands to
// alu_decoder.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } ctrl_state_t;

  // What the FSM asks of the ALU this cycle. FUNCT defers to the R-type
  // function field.
  typedef enum logic [1:0] {
    ALUC_ADD   = 2'd0,
    ALUC_SUB   = 2'd1,
    ALUC_FUNCT = 2'd2
  } alu_class_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decoder.
// Purpose: translate the FSM's ALU class and the R-type funct field into the
// 3-bit aluOp consumed by the ALU.
// Ports:
//   alu_class  in  2  ALUC_ADD / ALUC_SUB / ALUC_FUNCT
//   funct      in  6  instruction function field
//   aluOp      out 3  ALU operation
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] alu_class,
  input  logic [5:0] funct,
  output logic [2:0] aluOp
);

  always_comb begin
    aluOp = ALU_ADD;
    case (alu_class)
      ALUC_SUB: aluOp = ALU_SUB;
      ALUC_FUNCT: begin
        case (funct)
          FN_ADD:  aluOp = ALU_ADD;
          FN_SUB:  aluOp = ALU_SUB;
          FN_AND:  aluOp = ALU_AND;
          FN_OR:   aluOp = ALU_OR;
          FN_SLT:  aluOp = ALU_SLT;
          default: aluOp = ALU_ADD;
        endcase
      end
      default: aluOp = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit.
// Purpose: Moore FSM that sequences the shared ALU, register file, IR and
// unified memory port. memReady stretches FETCH, MEMRD and MEMWR.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   op, funct                  IR[31:26], IR[5:0]
//   zero                       ALU zero flag (branch resolve)
//   memReady                   memory finishes the current access this cycle
//   aluOp, aluSrcA, aluSrcB    ALU control / operand selects
//   pcSrc, pcEn                PC source select and load enable
//   iOrD                       memory address select (PC / ALUOut)
//   irWrite, memWrite, regWrite, regDst, memToReg   datapath controls
//   instrDone                  pulse on the last cycle of each instruction
//   illegalOp                  pulse in DECODE for an unsupported opcode
module mips_multicycle_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memReady,
  output logic [2:0] aluOp,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] pcSrc,
  output logic       pcEn,
  output logic       iOrD,
  output logic       irWrite,
  output logic       memWrite,
  output logic       regWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       instrDone,
  output logic       illegalOp
);

  ctrl_state_t state, state_nx;
  alu_class_t  alu_class;
  logic        pc_write, branch, ir_wr, mem_wr, reg_wr, done, illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    alu_class = ALUC_ADD;
    aluSrcA   = 1'b0;
    aluSrcB   = SRCB_B;
    pcSrc     = PC_ALU;
    iOrD      = 1'b0;
    regDst    = 1'b0;
    memToReg  = 1'b0;
    pc_write  = 1'b0;
    branch    = 1'b0;
    ir_wr     = 1'b0;
    mem_wr    = 1'b0;
    reg_wr    = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    case (state)
      S_FETCH: begin
        aluSrcB  = SRCB_4;
        ir_wr    = memReady;
        pc_write = memReady;
        if (memReady) state_nx = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut here.
        aluSrcB = SRCB_IMMSH;
        case (op)
          OP_LW, OP_SW: state_nx = S_MEMADR;
          OP_RTYPE:     state_nx = S_RTYPEEX;
          OP_BEQ:       state_nx = S_BEQEX;
          OP_ADDI:      state_nx = S_ADDIEX;
          OP_J:         state_nx = S_JEX;
          default: begin
            illegal  = 1'b1;
            done     = 1'b1;
            state_nx = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        aluSrcA  = 1'b1;
        aluSrcB  = SRCB_IMM;
        state_nx = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iOrD = 1'b1;
        if (memReady) state_nx = S_MEMWB;
      end
      S_MEMWB: begin
        reg_wr   = 1'b1;
        memToReg = 1'b1;
        done     = 1'b1;
        state_nx = S_FETCH;
      end
      S_MEMWR: begin
        // memWrite stays high for the whole stretched access.
        iOrD   = 1'b1;
        mem_wr = 1'b1;
        if (memReady) begin
          done     = 1'b1;
          state_nx = S_FETCH;
        end
      end
      S_RTYPEEX: begin
        aluSrcA   = 1'b1;
        aluSrcB   = SRCB_B;
        alu_class = ALUC_FUNCT;
        state_nx  = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        reg_wr   = 1'b1;
        regDst   = 1'b1;
        done     = 1'b1;
        state_nx = S_FETCH;
      end
      S_BEQEX: begin
        aluSrcA   = 1'b1;
        aluSrcB   = SRCB_B;
        alu_class = ALUC_SUB;
        pcSrc     = PC_ALUOUT;
        branch    = 1'b1;
        done      = 1'b1;
        state_nx  = S_FETCH;
      end
      S_ADDIEX: begin
        aluSrcA  = 1'b1;
        aluSrcB  = SRCB_IMM;
        state_nx = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_wr   = 1'b1;
        done     = 1'b1;
        state_nx = S_FETCH;
      end
      S_JEX: begin
        pcSrc    = PC_JUMP;
        pc_write = 1'b1;
        done     = 1'b1;
        state_nx = S_FETCH;
      end
      default: state_nx = S_FETCH;
    endcase
  end

  alu_decoder u_alu_dec (
    .alu_class (alu_class),
    .funct     (funct),
    .aluOp     (aluOp)
  );

  // The state register already sits in FETCH during reset, but FETCH with
  // memReady=1 would raise irWrite/pcEn. Gate every enable with rst_n so
  // nothing writes while reset is held.
  assign irWrite   = rst_n & ir_wr;
  assign pcEn      = rst_n & (pc_write | (branch & zero));
  assign memWrite  = rst_n & mem_wr;
  assign regWrite  = rst_n & reg_wr;
  assign instrDone = rst_n & done;
  assign illegalOp = rst_n & illegal;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl. An instruction-level model expands each
// instruction (op, funct, zero, memory wait counts) into its expected
// per-cycle output trace and drives the inputs to match. One compare process
// checks every cycle on the falling edge. Literal trace lengths pin the model.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, funct;
  logic       zero, memReady;
  logic [2:0] aluOp;
  logic       aluSrcA;
  logic [1:0] aluSrcB, pcSrc;
  logic       pcEn, iOrD, irWrite, memWrite, regWrite, regDst, memToReg;
  logic       instrDone, illegalOp;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] pc_src;
    logic       pc_en, i_or_d, ir_wr, mem_wr, reg_wr, reg_dst, mem_to_reg;
    logic       done, illegal;
  } exp_t;

  exp_t act, expv, rst_exp;
  logic exp_valid = 1'b0;
  int   n_chk = 0, n_pass = 0;
  int   bcnt, blim;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .memReady(memReady), .aluOp(aluOp), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .pcSrc(pcSrc), .pcEn(pcEn), .iOrD(iOrD), .irWrite(irWrite),
    .memWrite(memWrite), .regWrite(regWrite), .regDst(regDst),
    .memToReg(memToReg), .instrDone(instrDone), .illegalOp(illegalOp)
  );

  assign act = {aluOp, aluSrcA, aluSrcB, pcSrc, pcEn, iOrD, irWrite, memWrite,
                regWrite, regDst, memToReg, instrDone, illegalOp};

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h (op=%b funct=%b t=%0t)",
                  name, a, e, op, funct, $time);
  endtask

  always @(negedge clk)
    if (exp_valid && rst_n) chk("cycle", {15'b0, act}, {15'b0, expv});

  function automatic exp_t base();
    exp_t e;
    e = '0;
    e.alu_op = 3'b010;
    return e;
  endfunction

  function automatic logic rb();
    return $urandom_range(0, 1) == 1;
  endfunction

  function automatic logic [2:0] rfun(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // One cycle of expected behaviour; called at posedge+1. Beats beyond
  // blim are counted but not driven (used to abort mid-instruction).
  task automatic beat(input logic mr, input exp_t e);
    if (bcnt < blim) begin
      memReady  = mr;
      expv      = e;
      exp_valid = 1'b1;
      @(posedge clk); #1;
    end
    bcnt++;
  endtask

  // fw: memReady=0 cycles in FETCH; mw: memReady=0 cycles in MEMRD/MEMWR.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int fw, input int mw, input int cut, output int n);
    exp_t e;
    bcnt = 0; blim = cut;
    op = o; funct = f; zero = z;
    for (int i = 0; i <= fw; i++) begin
      e = base(); e.src_b = 2'b01; e.ir_wr = (i == fw); e.pc_en = (i == fw);
      beat(i == fw, e);
    end
    e = base(); e.src_b = 2'b11;
    if (!(o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010})) begin
      e.illegal = 1'b1; e.done = 1'b1;
      beat(rb(), e);
    end else begin
      beat(rb(), e);
      case (o)
        6'b100011, 6'b101011: begin
          e = base(); e.src_a = 1'b1; e.src_b = 2'b10;
          beat(rb(), e);
          for (int i = 0; i <= mw; i++) begin
            e = base(); e.i_or_d = 1'b1;
            if (o == 6'b101011) begin e.mem_wr = 1'b1; e.done = (i == mw); end
            beat(i == mw, e);
          end
          if (o == 6'b100011) begin
            e = base(); e.reg_wr = 1'b1; e.mem_to_reg = 1'b1; e.done = 1'b1;
            beat(rb(), e);
          end
        end
        6'b000000: begin
          e = base(); e.src_a = 1'b1; e.alu_op = rfun(f);
          beat(rb(), e);
          e = base(); e.reg_wr = 1'b1; e.reg_dst = 1'b1; e.done = 1'b1;
          beat(rb(), e);
        end
        6'b000100: begin
          e = base(); e.src_a = 1'b1; e.alu_op = 3'b110; e.pc_src = 2'b01;
          e.pc_en = z; e.done = 1'b1;
          beat(rb(), e);
        end
        6'b001000: begin
          e = base(); e.src_a = 1'b1; e.src_b = 2'b10;
          beat(rb(), e);
          e = base(); e.reg_wr = 1'b1; e.done = 1'b1;
          beat(rb(), e);
        end
        default: begin // j
          e = base(); e.pc_src = 2'b10; e.pc_en = 1'b1; e.done = 1'b1;
          beat(rb(), e);
        end
      endcase
    end
    n = bcnt;
  endtask

  initial begin
    int n;
    logic [5:0] ops [6];
    logic [5:0] fns [6];
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};
    rst_exp = base(); rst_exp.src_b = 2'b01;

    rst_n = 1'b0; op = 6'b0; funct = 6'b0; zero = 1'b1; memReady = 1'b1;
    #2 chk("por", {15'b0, act}, {15'b0, rst_exp});
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed instructions with literal lengths (memReady held 1).
    run_instr(6'b100011, 6'b0,      1'b0, 0, 0, 100, n); chk("len_lw",    n, 5);
    run_instr(6'b101011, 6'b0,      1'b0, 0, 0, 100, n); chk("len_sw",    n, 4);
    run_instr(6'b000000, 6'b100010, 1'b0, 0, 0, 100, n); chk("len_sub",   n, 4);
    run_instr(6'b000000, 6'b101010, 1'b0, 0, 0, 100, n); chk("len_slt",   n, 4);
    run_instr(6'b001000, 6'b0,      1'b0, 0, 0, 100, n); chk("len_addi",  n, 4);
    run_instr(6'b000100, 6'b0,      1'b1, 0, 0, 100, n); chk("len_beq1",  n, 3);
    run_instr(6'b000100, 6'b0,      1'b0, 0, 0, 100, n); chk("len_beq0",  n, 3);
    run_instr(6'b000010, 6'b0,      1'b0, 0, 0, 100, n); chk("len_j",     n, 3);
    run_instr(6'b111111, 6'b0,      1'b0, 0, 0, 100, n); chk("len_ill",   n, 2);
    run_instr(6'b100011, 6'b0,      1'b0, 0, 3, 100, n); chk("len_lw_w3", n, 8);
    run_instr(6'b101011, 6'b0,      1'b1, 2, 2, 100, n); chk("len_sw_w",  n, 8);

    // Reset asserted in the middle of RTYPEEX.
    run_instr(6'b000000, 6'b100010, 1'b1, 0, 0, 2, n);
    exp_valid = 1'b0; memReady = 1'b1; zero = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk("rst_async", {15'b0, act}, {15'b0, rst_exp});
    @(negedge clk); #1 chk("rst_hold_n", {15'b0, act}, {15'b0, rst_exp});
    @(posedge clk); #1 chk("rst_hold_p", {15'b0, act}, {15'b0, rst_exp});
    rst_n = 1'b1;
    run_instr(6'b000000, 6'b101010, 1'b0, 0, 0, 100, n); chk("len_post_rst", n, 4);

    // Randomized instruction stream.
    repeat (300) begin
      logic [5:0] o, f;
      o = (($urandom % 5) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
      f = (($urandom % 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
      run_instr(o, f, rb(), $urandom_range(0, 3), $urandom_range(0, 3), 100, n);
    end

    exp_valid = 1'b0;
    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
